if_id_buffer: RTL and testbench

- IF→ID pipeline register for the 5-stage CPU.
- Latches `{ce, pc}` from the fetch stage and pairs it with the synchronous-read `inst_sram_rdata`, which returns one cycle after the address.
- Holds the fetched instruction across ID stalls, so SRAM data is never lost or re-read.
- Drives a clean valid/pc/inst triple into ID; supports bubble insertion and flush.

---
 rtl/if_id_buffer_if.sv | 26 ++
 rtl/if_id_buffer.sv | 122 ++++++++++++
 tb/tb_if_id_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// IF->ID pipeline buffer bus: fetch-side inputs, stall/flush control and ID-side outputs.
interface if_id_buffer_if #(
   parameter int unsigned PC_WD    = 32,
   parameter int unsigned STALL_WD = 6
);
   logic [STALL_WD-1:0] stall;
   logic                flush;
   logic [PC_WD:0]      if_to_id_bus;
   logic [PC_WD-1:0]    inst_sram_rdata;
   logic                id_valid;
   logic [PC_WD-1:0]    id_pc;
   logic [PC_WD-1:0]    id_inst;
   logic                hold_active;

   // Pipeline environment (fetch stage, SRAM, hazard unit, ID stage)
   modport master (
      output stall, flush, if_to_id_bus, inst_sram_rdata,
      input  id_valid, id_pc, id_inst, hold_active
   );

   // The IF/ID buffer itself
   modport slave (
      input  stall, flush, if_to_id_bus, inst_sram_rdata,
      output id_valid, id_pc, id_inst, hold_active
   );
endinterface

// File: rtl/if_id_buffer.sv
// IF->ID pipeline register. Pairs the latched {ce, pc} with the one-cycle-late
// SRAM read data and parks that instruction in a hold register while ID stalls.
// Optional macro IFID_PERF_CNT_EN adds hold-cycle and bubble counters.
module if_id_buffer #(
   parameter int unsigned       PC_WD    = 32,
   parameter int unsigned       STALL_WD = 6,
   parameter logic [PC_WD-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   if_id_buffer_if.slave bus
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [31:0]   perf_hold_cycles,
   output logic [31:0]   perf_bubbles
`endif
);

   typedef enum logic {PASS = 1'b0, HELD = 1'b1} hold_state_e;

   hold_state_e      state_q, state_d;
   logic             valid_q, valid_d;
   logic [PC_WD-1:0] pc_q, pc_d;
   logic [PC_WD-1:0] hold_inst_q, hold_inst_d;

   logic             op_load, op_bubble, op_hold;
   logic             unused_stall;

   // Only the IF/ID and ID stall bits matter to this stage
   assign unused_stall = ^{bus.stall[0], bus.stall[STALL_WD-1:3]};

   // Decode the stall bus into the three update actions
   always_comb begin
      op_load   = !bus.stall[1];
      op_bubble = bus.stall[1] && !bus.stall[2];
      op_hold   = bus.stall[1] && bus.stall[2];
   end

   // Next-state: flush > load > bubble > hold; capture SRAM data on entry to HELD
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      pc_d        = pc_q;
      hold_inst_d = hold_inst_q;
      if (bus.flush) begin
         valid_d = 1'b0;
         pc_d    = RESET_PC;
         state_d = PASS;
      end else if (op_load) begin
         valid_d = bus.if_to_id_bus[PC_WD];
         pc_d    = bus.if_to_id_bus[PC_WD-1:0];
         state_d = PASS;
      end else if (op_bubble) begin
         valid_d = 1'b0;
         pc_d    = RESET_PC;
         state_d = PASS;
      end else begin
         case (state_q)
            PASS: begin
               if (valid_q) begin
                  state_d     = HELD;
                  hold_inst_d = bus.inst_sram_rdata;
               end
            end
            HELD: state_d = HELD;
            default: state_d = PASS;
         endcase
      end
   end

   // Pipeline and hold registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PASS;
         valid_q     <= 1'b0;
         pc_q        <= RESET_PC;
         hold_inst_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         hold_inst_q <= hold_inst_d;
      end
   end

   // ID-facing outputs: registered state plus the instruction source mux
   assign bus.id_valid    = valid_q;
   assign bus.id_pc       = pc_q;
   assign bus.hold_active = (state_q == HELD);
   assign bus.id_inst     = !valid_q ? '0
                          : ((state_q == HELD) ? hold_inst_q : bus.inst_sram_rdata);

`ifdef IFID_PERF_CNT_EN
   logic [31:0] hold_cnt_q, hold_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Count stalled valid entries and killed/bubbled slots; both wrap naturally
   always_comb begin
      hold_cnt_d   = hold_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (!bus.flush && op_hold && valid_q)
         hold_cnt_d = hold_cnt_q + 32'd1;
      if ((!bus.flush && op_bubble) || (bus.flush && valid_q))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt_q   <= '0;
         bubble_cnt_q <= '0;
      end else begin
         hold_cnt_q   <= hold_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_hold_cycles = hold_cnt_q;
   assign perf_bubbles     = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed scenarios plus random stall/flush traffic
// checked against a transaction-level model of what ID should see.
module tb_if_id_buffer;

   localparam int unsigned PC_WD    = 32;
   localparam int unsigned STALL_WD = 6;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

   logic clk;
   logic rst;

   if_id_buffer_if #(.PC_WD(PC_WD), .STALL_WD(STALL_WD)) bus ();

`ifdef IFID_PERF_CNT_EN
   logic [31:0] perf_hold_cycles;
   logic [31:0] perf_bubbles;
`endif

   if_id_buffer #(
      .PC_WD    (PC_WD),
      .STALL_WD (STALL_WD),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus.slave)
`ifdef IFID_PERF_CNT_EN
      ,
      .perf_hold_cycles (perf_hold_cycles),
      .perf_bubbles     (perf_bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Model of the ID-visible entry: which fetch (if any) ID currently holds
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_held;
   logic        m_last_load;
   logic [31:0] m_hold_cnt;
   logic [31:0] m_bubble_cnt;

   // Contents of instruction memory at a given address
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid      = 1'b0;
      m_pc         = RESET_PC;
      m_held       = 1'b0;
      m_last_load  = 1'b0;
      m_hold_cnt   = '0;
      m_bubble_cnt = '0;
   endtask

   // ID must see the instruction stored at its PC, or zero when nothing is valid
   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 32'(bus.id_valid), 32'(m_valid));
      check({tag, ".pc"},    bus.id_pc, m_pc);
      check({tag, ".inst"},  bus.id_inst, m_valid ? mem_word(m_pc) : 32'h0);
      check({tag, ".hold"},  32'(bus.hold_active), 32'(m_held));
`ifdef IFID_PERF_CNT_EN
      check({tag, ".phold"}, perf_hold_cycles, m_hold_cnt);
      check({tag, ".pbub"},  perf_bubbles, m_bubble_cnt);
`endif
   endtask

   // Apply one cycle of control, let the edge happen, play SRAM, then check ID
   task automatic step(input string tag, input logic f, input logic [5:0] s,
                       input logic ce, input logic [31:0] pc);
      bit was_valid;
      bus.flush        = f;
      bus.stall        = s;
      bus.if_to_id_bus = {ce, pc};
      @(posedge clk);
      #1;
      was_valid = m_valid;
      if (f) begin
         m_valid = 1'b0; m_pc = RESET_PC; m_held = 1'b0; m_last_load = 1'b0;
         if (was_valid) m_bubble_cnt++;
      end else if (!s[1]) begin
         m_valid = ce; m_pc = pc; m_held = 1'b0; m_last_load = 1'b1;
      end else if (!s[2]) begin
         m_valid = 1'b0; m_pc = RESET_PC; m_held = 1'b0; m_last_load = 1'b0;
         m_bubble_cnt++;
      end else begin
         m_held      = was_valid;
         m_last_load = 1'b0;
         if (was_valid) m_hold_cnt++;
      end
      // SRAM answers only for the address fetched at the last load; otherwise junk
      bus.inst_sram_rdata = m_last_load ? mem_word(pc) : GARBAGE;
      #1;
      check_outputs(tag);
   endtask

   localparam logic [5:0] S_RUN    = 6'b000000;
   localparam logic [5:0] S_HOLD   = 6'b000111;
   localparam logic [5:0] S_BUBBLE = 6'b000011;

   initial begin
      logic [31:0] a;
      rst                 = 1'b0;
      bus.flush           = 1'b0;
      bus.stall           = '0;
      bus.if_to_id_bus    = '0;
      bus.inst_sram_rdata = GARBAGE;
      model_reset();
      #3;
      check_outputs("por");
      rst = 1'b1;

      // First fetch after CPU reset has ce=0
      step("ce0", 1'b0, S_RUN, 1'b0, 32'hbfc0_0000);

      // Streaming
      a = 32'hbfc0_0100;
      for (int i = 0; i < 3; i++) step("stream", 1'b0, S_RUN, 1'b1, a + 32'(4 * i));

      // Hold for three edges, then release
      a = 32'h8000_1000;
      step("hold.load", 1'b0, S_RUN, 1'b1, a);
      for (int i = 0; i < 3; i++) step("hold", 1'b0, S_HOLD, 1'b1, a + 32'd4);
      step("hold.rel", 1'b0, S_RUN, 1'b1, a + 32'd4);

      // Bubble then recovery
      step("bubble", 1'b0, S_BUBBLE, 1'b1, a + 32'd8);
      step("bubble.rel", 1'b0, S_RUN, 1'b1, a + 32'd8);

      // Flush wins over a hold while HELD
      step("fl.load", 1'b0, S_RUN, 1'b1, a + 32'd12);
      step("fl.hold", 1'b0, S_HOLD, 1'b1, a + 32'd16);
      step("fl.hold2", 1'b0, S_HOLD, 1'b1, a + 32'd16);
      step("flush", 1'b1, S_HOLD, 1'b1, a + 32'd16);
      step("fl.idle", 1'b0, S_HOLD, 1'b1, a + 32'd16);

      // Async reset in mid-hold clears outputs without a clock edge
      step("rst.load", 1'b0, S_RUN, 1'b1, a + 32'd20);
      step("rst.hold", 1'b0, S_HOLD, 1'b1, a + 32'd24);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      check_outputs("async_rst");
      #2;
      rst = 1'b1;
      step("rst.first", 1'b0, S_RUN, 1'b1, 32'hbfc0_0000);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         logic       f, ce;
         logic [5:0] s;
         f  = ($urandom_range(0, 15) == 0);
         s  = 6'($urandom());
         if ($urandom_range(0, 9) < 5) s[1] = 1'b0;
         ce = ($urandom_range(0, 9) != 0);
         step("rand", f, s, ce, {$urandom()} & 32'hFFFF_FFFC);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
